// File: rtl/clock_display_scan.sv
// Time-multiplexed 6-digit common-anode 7-segment driver for the clock.
// Digits are snapshotted at each frame wrap; the set-mode digit blinks.
module clock_display_scan #(
  parameter int unsigned SCAN_DIV  = 100_000,
  parameter int unsigned BLINK_DIV = 25_000_000,
  parameter bit          LZ_BLANK  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic [2:0] pos,
  input  logic [3:0] sec_ones,
  input  logic [2:0] sec_tens,
  input  logic [3:0] min_ones,
  input  logic [2:0] min_tens,
  input  logic [3:0] hour_ones,
  input  logic [1:0] hour_tens,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned SW = (SCAN_DIV  > 2) ? $clog2(SCAN_DIV)  : 1;
  localparam int unsigned BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [1:0]    MODE_SET   = 2'b01;

  typedef enum logic [2:0] {
    IDX_S1  = 3'd0,
    IDX_S10 = 3'd1,
    IDX_M1  = 3'd2,
    IDX_M10 = 3'd3,
    IDX_H1  = 3'd4,
    IDX_H10 = 3'd5
  } idx_e;

  logic [SW-1:0] r_scan_cnt;
  logic [BW-1:0] r_blink_cnt;
  logic          r_phase;
  idx_e          r_idx;
  logic [3:0]    r_snap_s1, r_snap_m1, r_snap_h1;
  logic [2:0]    r_snap_s10, r_snap_m10;
  logic [1:0]    r_snap_h10;
  logic [7:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;

  logic       w_scan_tick;
  idx_e       w_idx_next;
  logic [3:0] w_digit;
  logic [7:0] w_an;
  logic [6:0] w_seg;
  logic       w_dp;
  logic [2:0] w_pos_idx;
  logic       w_blink_blank;
  logic       w_lz_blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  assign w_scan_tick = (r_scan_cnt == SCAN_LAST);

  always_comb begin
    w_idx_next = IDX_S1;
    w_digit    = '0;
    w_an       = '1;
    case (r_idx)
      IDX_S1:  begin w_idx_next = IDX_S10; w_digit = r_snap_s1;          w_an = 8'hFE; end
      IDX_S10: begin w_idx_next = IDX_M1;  w_digit = {1'b0, r_snap_s10}; w_an = 8'hFD; end
      IDX_M1:  begin w_idx_next = IDX_M10; w_digit = r_snap_m1;          w_an = 8'hFB; end
      IDX_M10: begin w_idx_next = IDX_H1;  w_digit = {1'b0, r_snap_m10}; w_an = 8'hF7; end
      IDX_H1:  begin w_idx_next = IDX_H10; w_digit = r_snap_h1;          w_an = 8'hEF; end
      IDX_H10: begin w_idx_next = IDX_S1;  w_digit = {2'b0, r_snap_h10}; w_an = 8'hDF; end
      default: begin w_idx_next = IDX_S1;  w_digit = '0;                 w_an = 8'hFF; end
    endcase
  end

  // pos counts digits left-to-right, idx counts right-to-left
  assign w_pos_idx     = 3'd6 - pos;
  assign w_blink_blank = (mode == MODE_SET) && r_phase && (pos != 3'd0) && (pos != 3'd7)
                         && (3'(r_idx) == w_pos_idx);
  assign w_lz_blank    = LZ_BLANK && (r_idx == IDX_H10) && (r_snap_h10 == 2'd0);
  assign w_seg         = (w_blink_blank || w_lz_blank) ? 7'h7F : seg_decode(w_digit);
  assign w_dp          = !((r_idx == IDX_M1) || (r_idx == IDX_H1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan_cnt  <= '0;
      r_idx       <= IDX_S1;
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
      r_snap_s1   <= '0;
      r_snap_s10  <= '0;
      r_snap_m1   <= '0;
      r_snap_m10  <= '0;
      r_snap_h1   <= '0;
      r_snap_h10  <= '0;
      r_an        <= '1;
      r_seg       <= '1;
      r_dp        <= 1'b1;
    end else begin
      if (w_scan_tick) begin
        r_scan_cnt <= '0;
        r_idx      <= w_idx_next;
        if (r_idx == IDX_H10) begin
          r_snap_s1  <= sec_ones;
          r_snap_s10 <= sec_tens;
          r_snap_m1  <= min_ones;
          r_snap_m10 <= min_tens;
          r_snap_h1  <= hour_ones;
          r_snap_h10 <= hour_tens;
        end
      end else begin
        r_scan_cnt <= r_scan_cnt + SW'(1);
      end
      // Held cleared outside set mode so entering set mode always starts visible
      if (mode != MODE_SET) begin
        r_blink_cnt <= '0;
        r_phase     <= 1'b0;
      end else if (r_blink_cnt == BLINK_LAST) begin
        r_blink_cnt <= '0;
        r_phase     <= ~r_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + BW'(1);
      end
      r_an  <= w_an;
      r_seg <= w_seg;
      r_dp  <= w_dp;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule

// File: tb/tb_clock_display_scan.sv
// Scoreboard bench for clock_display_scan (SCAN_DIV=4, BLINK_DIV=64).
module tb_clock_display_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode = 2'b00;
  logic [2:0] pos = 3'd0;
  logic [3:0] sec_ones = 4'd0, min_ones = 4'd0, hour_ones = 4'd0;
  logic [2:0] sec_tens = 3'd0, min_tens = 3'd0;
  logic [1:0] hour_tens = 2'd0;
  logic [7:0] an, an_lz;
  logic [6:0] seg, seg_lz;
  logic       dp, dp_lz;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t q[$];
  exp_t q_lz[$];

  clock_display_scan #(.SCAN_DIV(4), .BLINK_DIV(64), .LZ_BLANK(1'b0)) dut (
    .clk(clk), .rst(rst), .mode(mode), .pos(pos),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones), .min_tens(min_tens),
    .hour_ones(hour_ones), .hour_tens(hour_tens), .an(an), .seg(seg), .dp(dp));

  clock_display_scan #(.SCAN_DIV(4), .BLINK_DIV(64), .LZ_BLANK(1'b1)) dut_lz (
    .clk(clk), .rst(rst), .mode(mode), .pos(pos),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones), .min_tens(min_tens),
    .hour_ones(hour_ones), .hour_tens(hour_tens), .an(an_lz), .seg(seg_lz), .dp(dp_lz));

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic exp_t make_exp(input int i, input int d, input bit blank);
    logic [7:0] an_tab [6];
    exp_t e;
    an_tab = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF};
    e.an  = an_tab[i];
    e.seg = blank ? 7'h7F : seg_of(d);
    e.dp  = (i == 2 || i == 4) ? 1'b0 : 1'b1;
    return e;
  endfunction

  // Digits ordered by scan position: s1, s10, m1, m10, h1, h10
  task automatic push_frame(input int d[6], input logic [5:0] bmask, input bit to_lz);
    for (int i = 0; i < 6; i++)
      for (int k = 0; k < 4; k++)
        if (to_lz) q_lz.push_back(make_exp(i, d[i], bmask[i]));
        else       q.push_back(make_exp(i, d[i], bmask[i]));
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_time(input int h10, input int h1, input int m10, input int m1,
                          input int s10, input int s1);
    hour_tens = 2'(h10); hour_ones = 4'(h1);
    min_tens  = 3'(m10); min_ones  = 4'(m1);
    sec_tens  = 3'(s10); sec_ones  = 4'(s1);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    exp_t e;
    set_time(0, 0, 0, 0, 0, 0);
    mode = 2'b00; pos = 3'd0;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if ({an, seg, dp} !== {8'hFF, 7'h7F, 1'b1}) begin
        failures++;
        $display("FAIL reset_hold c=%0d an=%h seg=%b dp=%b exp an=ff seg=1111111 dp=1", c, an, seg, dp);
      end
    end
    rst = 1'b0;
    q.push_back(make_exp(0, 0, 1'b0));
    step();
    e = q.pop_front();
    checks++;
    if ({an, seg, dp} !== {e.an, e.seg, e.dp}) begin
      failures++;
      $display("FAIL reset_release an=%h seg=%b dp=%b exp an=%h seg=%b dp=%b", an, seg, dp, e.an, e.seg, e.dp);
    end
  endtask

  task automatic test_frame;
    exp_t e;
    int z[6] = '{0, 0, 0, 0, 0, 0};
    int d[6] = '{6, 5, 4, 3, 2, 1};
    set_time(1, 2, 3, 4, 5, 6);
    mode = 2'b00;
    do_reset();
    push_frame(z, 6'b0, 1'b0);
    push_frame(d, 6'b0, 1'b0);
    for (int c = 0; c < 48; c++) begin
      step();
      e = q.pop_front();
      checks++;
      if ({an, seg, dp} !== {e.an, e.seg, e.dp}) begin
        failures++;
        $display("FAIL frame c=%0d an=%h seg=%b dp=%b exp an=%h seg=%b dp=%b", c, an, seg, dp, e.an, e.seg, e.dp);
      end
    end
  endtask

  task automatic test_snapshot;
    exp_t e;
    int z[6]  = '{0, 0, 0, 0, 0, 0};
    int d[6]  = '{6, 5, 4, 3, 2, 1};
    int d2[6] = '{7, 5, 4, 4, 2, 1};
    set_time(1, 2, 3, 4, 5, 6);
    do_reset();
    push_frame(z, 6'b0, 1'b0);
    push_frame(d, 6'b0, 1'b0);
    push_frame(d, 6'b0, 1'b0);
    push_frame(d2, 6'b0, 1'b0);
    for (int c = 0; c < 96; c++) begin
      step();
      e = q.pop_front();
      checks++;
      if ({an, seg, dp} !== {e.an, e.seg, e.dp}) begin
        failures++;
        $display("FAIL snapshot c=%0d an=%h seg=%b dp=%b exp an=%h seg=%b dp=%b", c, an, seg, dp, e.an, e.seg, e.dp);
      end
      if (c == 56) begin
        sec_ones = 4'd7;
        min_tens = 3'd4;
      end
    end
  endtask

  task automatic test_blink;
    exp_t e;
    int z[6] = '{0, 0, 0, 0, 0, 0};
    int d[6] = '{6, 5, 4, 3, 2, 1};
    set_time(1, 2, 3, 4, 5, 6);
    mode = 2'b00; pos = 3'd3;
    do_reset();
    push_frame(z, 6'b0, 1'b0);
    for (int f = 1; f < 8; f++)
      push_frame(d, (f == 5 || f == 6) ? 6'b001000 : 6'b0, 1'b0);
    for (int c = 0; c < 192; c++) begin
      step();
      e = q.pop_front();
      checks++;
      if ({an, seg, dp} !== {e.an, e.seg, e.dp}) begin
        failures++;
        $display("FAIL blink c=%0d an=%h seg=%b dp=%b exp an=%h seg=%b dp=%b", c, an, seg, dp, e.an, e.seg, e.dp);
      end
      if (c == 47) mode = 2'b01;
    end
  endtask

  task automatic test_blank_cases;
    exp_t e, e2;
    int z[6]  = '{0, 0, 0, 0, 0, 0};
    int d5[6] = '{7, 5, 4, 4, 12, 0};
    set_time(0, 12, 4, 4, 5, 7);
    mode = 2'b01; pos = 3'd0;
    do_reset();
    push_frame(z, 6'b0, 1'b0);
    push_frame(z, 6'b100000, 1'b1);
    for (int f = 1; f < 4; f++) begin
      push_frame(d5, 6'b0, 1'b0);
      push_frame(d5, 6'b100000, 1'b1);
    end
    for (int c = 0; c < 96; c++) begin
      step();
      e  = q.pop_front();
      e2 = q_lz.pop_front();
      checks++;
      if ({an, seg, dp} !== {e.an, e.seg, e.dp}) begin
        failures++;
        $display("FAIL bad_bcd_pos0 c=%0d an=%h seg=%b dp=%b exp an=%h seg=%b dp=%b", c, an, seg, dp, e.an, e.seg, e.dp);
      end
      checks++;
      if ({an_lz, seg_lz, dp_lz} !== {e2.an, e2.seg, e2.dp}) begin
        failures++;
        $display("FAIL lz_blank c=%0d an=%h seg=%b dp=%b exp an=%h seg=%b dp=%b", c, an_lz, seg_lz, dp_lz, e2.an, e2.seg, e2.dp);
      end
    end
  endtask

  task automatic test_mid_reset;
    exp_t e;
    int z[6] = '{0, 0, 0, 0, 0, 0};
    int d[6] = '{6, 5, 4, 3, 2, 1};
    set_time(1, 2, 3, 4, 5, 6);
    mode = 2'b00; pos = 3'd0;
    do_reset();
    push_frame(z, 6'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 4; k++) q.push_back(make_exp(i, d[i], 1'b0));
    q.push_back(make_exp(3, d[3], 1'b0));
    for (int c = 0; c < 37; c++) begin
      step();
      e = q.pop_front();
      checks++;
      if ({an, seg, dp} !== {e.an, e.seg, e.dp}) begin
        failures++;
        $display("FAIL pre_reset c=%0d an=%h seg=%b dp=%b exp an=%h seg=%b dp=%b", c, an, seg, dp, e.an, e.seg, e.dp);
      end
    end
    rst = 1'b1;
    step();
    checks++;
    if ({an, seg, dp} !== {8'hFF, 7'h7F, 1'b1}) begin
      failures++;
      $display("FAIL mid_reset an=%h seg=%b dp=%b exp an=ff seg=1111111 dp=1", an, seg, dp);
    end
    rst = 1'b0;
    push_frame(z, 6'b0, 1'b0);
    push_frame(d, 6'b0, 1'b0);
    for (int c = 0; c < 48; c++) begin
      step();
      e = q.pop_front();
      checks++;
      if ({an, seg, dp} !== {e.an, e.seg, e.dp}) begin
        failures++;
        $display("FAIL post_reset c=%0d an=%h seg=%b dp=%b exp an=%h seg=%b dp=%b", c, an, seg, dp, e.an, e.seg, e.dp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_snapshot();
    test_blink();
    test_blank_cases();
    test_mid_reset();
    checks++;
    if (q.size() != 0 || q_lz.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d left_lz=%0d exp 0", q.size(), q_lz.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
